// File: rtl/cms_pkg.sv
// Shared definitions for the continuous-monitoring trace path: packet field
// offsets, default packet width and the serializer state encoding.
package cms_pkg;

    // Field offsets inside one trace packet (pc 64 + instr 32 + extra 64).
    localparam int PC_LSB       = 0;
    localparam int INSTR_LSB    = 64;
    localparam int EXTRA_LSB    = 96;

    // Default trace packet width.
    localparam int CMS_IN_WIDTH = 160;

    // Serializer states: nothing held / holding a packet being sent out.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } cms_state_e;

endpackage

// File: rtl/cms_axis_width_down.sv
// Wide-to-narrow AXI-Stream serializer: holds one wide packet and emits it
// as NBEATS narrow beats, LSB slice first. The next packet is accepted in the
// same cycle as the final beat handshake, so a stream of packets has no bubbles.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid & ready are both 1. Once m_valid is raised, m_data/m_last hold
// stable until the beat is taken. s_ready may depend combinationally on
// m_ready (only while the final beat is presented).
import cms_pkg::*;

module cms_axis_width_down #(
    parameter int IN_WIDTH  = CMS_IN_WIDTH,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last
);

    localparam int NBEATS = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
        $error("cms_axis_width_down: IN_WIDTH must be a multiple of OUT_WIDTH");
    end

    cms_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IN_WIDTH-1:0]  hold_q, hold_d;
    logic                 hold_last_q, hold_last_d;
    logic                 live_q, live_d;

    logic                 last_beat;
    logic                 m_fire;
    logic                 s_fire;
    logic [OUT_WIDTH-1:0] beat_w [NBEATS];

    // Split the holding register into addressable beats.
    for (genvar b = 0; b < NBEATS; b++) begin : g_beats
        assign beat_w[b] = hold_q[b*OUT_WIDTH +: OUT_WIDTH];
    end

    assign last_beat = (idx_q == LAST_IDX);
    assign m_valid   = (state_q == ST_SEND);
    assign m_data    = beat_w[idx_q];
    assign m_last    = m_valid & hold_last_q & last_beat;
    assign m_fire    = m_valid & m_ready;
    // live_q keeps s_ready low while rst is asserted and for the reset cycle.
    assign s_ready   = live_q & ((state_q == ST_EMPTY) | (last_beat & m_ready));
    assign s_fire    = s_valid & s_ready;

    // Next-state logic: load on accept, step idx on each beat handshake.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        live_d      = 1'b1;
        case (state_q)
            ST_EMPTY: begin
                if (s_fire) begin
                    hold_d      = s_data;
                    hold_last_d = s_last;
                    idx_d       = '0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_fire) begin
                    if (last_beat) begin
                        idx_d = '0;
                        if (s_fire) begin
                            hold_d      = s_data;
                            hold_last_d = s_last;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Serializer registers; reset drops any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            idx_q       <= '0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            live_q      <= live_d;
        end
    end

endmodule

// File: rtl/cms_trace_axis_receiver.sv
// Receives wide trace packets from the monitor, re-emits them as narrow beats
// and keeps software-visible packet/frame counters plus a sticky flag that
// records any tlast arriving at a position other than tlast_interval.
import cms_pkg::*;

module cms_trace_axis_receiver #(
    parameter int IN_WIDTH  = CMS_IN_WIDTH,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                 S_AXIS_tlast,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
    output logic                 M_AXIS_tlast,
    input  logic [CNT_WIDTH-1:0] tlast_interval,
    input  logic                 clear_status,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic                 tlast_err
);

    logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
    logic [CNT_WIDTH-1:0] frame_q, frame_d;
    logic [CNT_WIDTH-1:0] fc_q, fc_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic                 expected;

    cms_axis_width_down #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_width_down (
        .clk     (clk),
        .rst     (rst),
        .s_valid (S_AXIS_tvalid),
        .s_ready (S_AXIS_tready),
        .s_data  (S_AXIS_tdata),
        .s_last  (S_AXIS_tlast),
        .m_valid (M_AXIS_tvalid),
        .m_ready (M_AXIS_tready),
        .m_data  (M_AXIS_tdata),
        .m_last  (M_AXIS_tlast)
    );

    assign accept   = S_AXIS_tvalid & S_AXIS_tready;
    // fc counts packets since the last tlast; the frame should close on packet tlast_interval.
    assign expected = (fc_q == (tlast_interval - CNT_WIDTH'(1)));

    // Counter / tlast-position checker update; clear_status overrides the accept.
    always_comb begin
        pkt_d   = pkt_q;
        frame_d = frame_q;
        fc_d    = fc_q;
        err_d   = err_q;
        if (accept) begin
            pkt_d = pkt_q + CNT_WIDTH'(1);
            if (S_AXIS_tlast) begin
                frame_d = frame_q + CNT_WIDTH'(1);
            end
            if (tlast_interval != '0) begin
                if (S_AXIS_tlast != expected) begin
                    err_d = 1'b1;
                end
                fc_d = (S_AXIS_tlast || expected) ? '0 : fc_q + CNT_WIDTH'(1);
            end else begin
                fc_d = S_AXIS_tlast ? '0 : fc_q + CNT_WIDTH'(1);
            end
        end
        if (clear_status) begin
            pkt_d   = accept ? CNT_WIDTH'(1) : '0;
            frame_d = (accept && S_AXIS_tlast) ? CNT_WIDTH'(1) : '0;
            fc_d    = '0;
            err_d   = 1'b0;
        end
    end

    // Status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q   <= '0;
            frame_q <= '0;
            fc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            pkt_q   <= pkt_d;
            frame_q <= frame_d;
            fc_q    <= fc_d;
            err_q   <= err_d;
        end
    end

    assign pkt_count   = pkt_q;
    assign frame_count = frame_q;
    assign tlast_err   = err_q;

endmodule

// File: tb/tb_cms_trace_axis_receiver.sv
// Bench for cms_trace_axis_receiver: directed packets, expected beats queued
// by the driver and checked by an independent output monitor.
module tb_cms_trace_axis_receiver;

    localparam int IN_W  = 160;
    localparam int OUT_W = 32;
    localparam int CW    = 32;
    localparam int NB    = IN_W / OUT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [IN_W-1:0]   s_data = '0;
    logic              s_last = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [OUT_W-1:0]  m_data;
    logic              m_last;
    logic [CW-1:0]     tlast_interval = '0;
    logic              clear_status = 1'b0;
    logic [CW-1:0]     pkt_count;
    logic [CW-1:0]     frame_count;
    logic              tlast_err;

    int                checks = 0;
    int                failures = 0;
    logic [OUT_W:0]    exp_q[$];
    logic              tog_mode = 1'b0;

    cms_trace_axis_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .S_AXIS_tvalid  (s_valid),
        .S_AXIS_tready  (s_ready),
        .S_AXIS_tdata   (s_data),
        .S_AXIS_tlast   (s_last),
        .M_AXIS_tvalid  (m_valid),
        .M_AXIS_tready  (m_ready),
        .M_AXIS_tdata   (m_data),
        .M_AXIS_tlast   (m_last),
        .tlast_interval (tlast_interval),
        .clear_status   (clear_status),
        .pkt_count      (pkt_count),
        .frame_count    (frame_count),
        .tlast_err      (tlast_err)
    );

    // clock
    always #5 clk = ~clk;

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", nm);
    endtask

    function automatic logic [IN_W-1:0] mk(input logic [31:0] base);
        logic [IN_W-1:0] r;
        for (int i = 0; i < NB; i++) r[i*OUT_W +: OUT_W] = base + 32'(i);
        return r;
    endfunction

    // downstream ready driver: constant 1 or toggling each cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_mode) m_ready = ~m_ready;
            else          m_ready = 1'b1;
        end
    end

    // output monitor: pops expected beats, checks stability during stalls
    initial begin
        logic           stall_prev;
        logic [OUT_W:0] held;
        logic [OUT_W:0] e;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (stall_prev) chk("stall_hold", {31'd0, m_valid, m_last, m_data}, {31'd0, 1'b1, held});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h expected=none", {m_last, m_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {31'd0, m_last, m_data}, {31'd0, e});
                end
            end
            stall_prev = m_valid && !m_ready && !rst;
            held       = {m_last, m_data};
        end
    end

    // driver: offer one packet, return #1 after the accepting edge
    task automatic send(input logic [IN_W-1:0] d, input logic l);
        int t;
        for (int i = 0; i < NB; i++) exp_q.push_back({l && (i == NB - 1), d[i*OUT_W +: OUT_W]});
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || m_valid) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        @(posedge clk);
        #1;
        clear_status = 1'b0;
    endtask

    initial begin
        logic [IN_W-1:0] p;
        int n, first, last_c, rh;

        // ---- reset
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_tlast_err", 64'(tlast_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;

        // ---- 1: single packet, words 0..4
        send(mk(32'd0), 1'b0);
        chk("t1_latency_valid", 64'(m_valid), 64'd1);
        chk("t1_latency_data", 64'(m_data), 64'd0);
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);
        wait_drain();

        // ---- 2: 4 packets back to back, contiguous beats
        n = 0; first = -1; last_c = -1; rh = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(mk(32'h2000_0000 + 32'(k * 16)), 1'b0);
            end
            begin
                for (int c = 0; c < 400 && n < 20; c++) begin
                    @(negedge clk);
                    if (m_valid && m_ready) begin
                        if (n == 0) first = c;
                        n++;
                        last_c = c;
                        if (s_ready) rh++;
                    end
                end
            end
        join
        chk("t2_beats", 64'(n), 64'd20);
        chk("t2_span", 64'(last_c - first), 64'd19);
        chk("t2_s_ready_cycles", 64'(rh), 64'd4);
        chk("t2_pkt_count", 64'(pkt_count), 64'd5);
        wait_drain();

        // ---- 3: toggling downstream ready
        tog_mode = 1'b1;
        send(mk(32'h3000_0000), 1'b0);
        send(mk(32'h3100_0000), 1'b0);
        wait_drain();
        tog_mode = 1'b0;
        chk("t3_pkt_count", 64'(pkt_count), 64'd7);
        @(posedge clk);
        #1;

        // ---- 4: tlast interval check
        pulse_clear();
        chk("t4_clear_pkt", 64'(pkt_count), 64'd0);
        tlast_interval = 32'd3;
        for (int k = 1; k <= 6; k++) send(mk(32'h4000_0000 + 32'(k * 16)), (k == 3) || (k == 6));
        chk("t4_err_ok", 64'(tlast_err), 64'd0);
        chk("t4_frames", 64'(frame_count), 64'd2);
        send(mk(32'h4700_0000), 1'b0);
        send(mk(32'h4800_0000), 1'b1);
        chk("t4_err_set", 64'(tlast_err), 64'd1);
        chk("t4_pkt_count", 64'(pkt_count), 64'd8);
        chk("t4_frames3", 64'(frame_count), 64'd3);
        wait_drain();
        clear_status = 1'b1;
        send(mk(32'h4900_0000), 1'b0);
        clear_status = 1'b0;
        chk("t4_clr_acc_err", 64'(tlast_err), 64'd0);
        chk("t4_clr_acc_pkt", 64'(pkt_count), 64'd1);
        chk("t4_clr_acc_frame", 64'(frame_count), 64'd0);
        wait_drain();

        // ---- 5: reset in the middle of a packet
        send(mk(32'h5000_0000), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_beats_left", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(m_valid), 64'd0);
        chk("t5_rst_last", 64'(m_last), 64'd0);
        chk("t5_rst_pkt", 64'(pkt_count), 64'd0);
        chk("t5_rst_ready", 64'(s_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        p = mk(32'h5500_0000);
        send(p, 1'b0);
        chk("t5_restart_beat0", 64'(m_data), 64'h5500_0000);
        wait_drain();

        // ---- 6: interval disabled, random tlast; clear with accept
        tlast_interval = '0;
        for (int k = 0; k < 6; k++) send(mk(32'h6000_0000 + 32'(k * 16)), 1'($urandom_range(0, 1)));
        chk("t6_no_err", 64'(tlast_err), 64'd0);
        wait_drain();
        clear_status = 1'b1;
        send(mk(32'h6600_0000), 1'b1);
        clear_status = 1'b0;
        chk("t6_clr_pkt", 64'(pkt_count), 64'd1);
        chk("t6_clr_frame", 64'(frame_count), 64'd1);
        chk("t6_clr_err", 64'(tlast_err), 64'd0);
        wait_drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
